// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the 4-stage CPU pipeline control:
//   - MEM-stage control operation codes (CTRL_OP_*)
//   - control-register addresses (CREG_ADDR_*)
//   - exception codes (ISA_EXP_*)
//   - bit locations inside STATUS and CAUSE
//   - execution modes and release identification
//   - the commit kind selected by pipe_ctrl and acted on by creg_file
// ----------------------------------------------------------------------------
package cpu_pkg;

   // MEM-stage control operations carried on mem_ctrl_op
   localparam logic [1:0] CTRL_OP_NOP  = 2'd0;
   localparam logic [1:0] CTRL_OP_WRCR = 2'd1;
   localparam logic [1:0] CTRL_OP_EXRT = 2'd2;

   // Control-register address map (address 3 and 11..31 are unmapped)
   localparam logic [4:0] CREG_ADDR_STATUS     = 5'd0;
   localparam logic [4:0] CREG_ADDR_PRE_STATUS = 5'd1;
   localparam logic [4:0] CREG_ADDR_EPC        = 5'd2;
   localparam logic [4:0] CREG_ADDR_EXP_VECTOR = 5'd4;
   localparam logic [4:0] CREG_ADDR_CAUSE      = 5'd5;
   localparam logic [4:0] CREG_ADDR_INT_MASK   = 5'd6;
   localparam logic [4:0] CREG_ADDR_IRQ        = 5'd7;
   localparam logic [4:0] CREG_ADDR_ROM_SIZE   = 5'd8;
   localparam logic [4:0] CREG_ADDR_SPM_SIZE   = 5'd9;
   localparam logic [4:0] CREG_ADDR_CPU_INFO   = 5'd10;

   // Exception codes; zero means no exception
   localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
   localparam logic [2:0] ISA_EXP_EXT_INT    = 3'd1;
   localparam logic [2:0] ISA_EXP_UNDEF_INSN = 3'd2;
   localparam logic [2:0] ISA_EXP_OVERFLOW   = 3'd3;
   localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'd4;
   localparam logic [2:0] ISA_EXP_TRAP       = 3'd5;
   localparam logic [2:0] ISA_EXP_PRV_VIO    = 3'd6;

   // Bit locations inside STATUS and CAUSE
   localparam int CregExeModeLoc   = 0;
   localparam int CregIntEnableLoc = 1;
   localparam int CregExpCodeLoc   = 0;
   localparam int CregDlyFlagLoc   = 31;

   // Execution modes
   localparam logic CPU_KERNEL_MODE = 1'b0;
   localparam logic CPU_USER_MODE   = 1'b1;

   // Release identification returned by CPU_INFO
   localparam logic [7:0] RELEASE_YEAR     = 8'h24;
   localparam logic [7:0] RELEASE_MONTH    = 8'h06;
   localparam logic [7:0] RELEASE_VERSION  = 8'h01;
   localparam logic [7:0] RELEASE_REVISION = 8'h00;

   // What the MEM stage commits this cycle (already prioritised)
   typedef enum logic [1:0] {
      COMMIT_NONE = 2'd0,
      COMMIT_EXP  = 2'd1,
      COMMIT_EXRT = 2'd2,
      COMMIT_WRCR = 2'd3
   } commit_e;

   // Assemble the STATUS read word from its two live bits
   function automatic logic [31:0] creg_status_word(input logic int_en, input logic exe_mode);
      logic [31:0] w;
      w = 32'd0;
      w[CregIntEnableLoc] = int_en;
      w[CregExeModeLoc]   = exe_mode;
      return w;
   endfunction

endpackage

// File: rtl/creg_file.sv
// ----------------------------------------------------------------------------
// creg_file
// Control-register storage (STATUS, PRE_STATUS, EPC, EXP_VECTOR, CAUSE,
// INT_MASK), commit-driven update and the combinational RDCR read mux.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_commit          prioritised commit kind from pipe_ctrl
//   i_mem_pc          PC of the committing instruction (word address)
//   i_mem_br_flag     committing instruction sits in a branch delay slot
//   i_mem_exp_code    exception code to latch into CAUSE
//   i_mem_dst_addr    WRCR destination address
//   i_mem_out         WRCR write data
//   i_irq             raw interrupt lines (readable through IRQ)
//   i_rd_addr         read address from the decoder
//   o_rd_data         read data (old value on a same-cycle write)
//   o_exe_mode        STATUS.exe_mode
//   o_int_en          STATUS.int_en
//   o_epc             EPC (word address), EXRT target
//   o_exp_vector      EXP_VECTOR (word address), exception target
//   o_int_mask        per-line interrupt mask (1 = masked)
// ----------------------------------------------------------------------------
module creg_file
   import cpu_pkg::*;
#(
   parameter int          IRQ_CH         = 8,
   parameter logic [29:0] EXP_VECTOR_RST = 30'h0,
   parameter logic [31:0] ROM_SIZE       = 32'h2000,
   parameter logic [31:0] SPM_SIZE       = 32'h4000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  commit_e           i_commit,
   input  logic [29:0]       i_mem_pc,
   input  logic              i_mem_br_flag,
   input  logic [2:0]        i_mem_exp_code,
   input  logic [4:0]        i_mem_dst_addr,
   input  logic [31:0]       i_mem_out,
   input  logic [IRQ_CH-1:0] i_irq,
   input  logic [4:0]        i_rd_addr,
   output logic [31:0]       o_rd_data,
   output logic              o_exe_mode,
   output logic              o_int_en,
   output logic [29:0]       o_epc,
   output logic [29:0]       o_exp_vector,
   output logic [IRQ_CH-1:0] o_int_mask
);

   logic        r_exe_mode;
   logic        r_int_en;
   logic        r_pre_exe_mode;
   logic        r_pre_int_en;
   logic [29:0] r_epc;
   logic [29:0] r_exp_vector;
   logic [2:0]  r_exp_code;
   logic        r_dly_flag;
   logic [31:0] r_int_mask;

   logic [29:0] w_epc_next;
   logic [31:0] w_irq_ext;

   // A delay-slot instruction restarts at its branch, one word earlier
   assign w_epc_next = i_mem_br_flag ? (i_mem_pc - 30'd1) : i_mem_pc;

   // Register update on commit; reset wins over any same-edge commit
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_exe_mode     <= CPU_KERNEL_MODE;
         r_int_en       <= 1'b0;
         r_pre_exe_mode <= 1'b0;
         r_pre_int_en   <= 1'b0;
         r_epc          <= 30'd0;
         r_exp_vector   <= EXP_VECTOR_RST;
         r_exp_code     <= 3'd0;
         r_dly_flag     <= 1'b0;
         r_int_mask     <= 32'hFFFF_FFFF;
      end else begin
         case (i_commit)
            COMMIT_EXP: begin
               r_exp_code     <= i_mem_exp_code;
               r_epc          <= w_epc_next;
               r_dly_flag     <= i_mem_br_flag;
               r_pre_exe_mode <= r_exe_mode;
               r_pre_int_en   <= r_int_en;
               r_exe_mode     <= CPU_KERNEL_MODE;
               r_int_en       <= 1'b0;
            end
            COMMIT_EXRT: begin
               r_exe_mode <= r_pre_exe_mode;
               r_int_en   <= r_pre_int_en;
            end
            COMMIT_WRCR: begin
               case (i_mem_dst_addr)
                  CREG_ADDR_STATUS: begin
                     r_exe_mode <= i_mem_out[CregExeModeLoc];
                     r_int_en   <= i_mem_out[CregIntEnableLoc];
                  end
                  CREG_ADDR_PRE_STATUS: begin
                     r_pre_exe_mode <= i_mem_out[CregExeModeLoc];
                     r_pre_int_en   <= i_mem_out[CregIntEnableLoc];
                  end
                  CREG_ADDR_EPC:        r_epc        <= i_mem_out[31:2];
                  CREG_ADDR_EXP_VECTOR: r_exp_vector <= i_mem_out[31:2];
                  CREG_ADDR_CAUSE: begin
                     r_dly_flag <= i_mem_out[CregDlyFlagLoc];
                     r_exp_code <= i_mem_out[CregExpCodeLoc +: 3];
                  end
                  CREG_ADDR_INT_MASK:   r_int_mask   <= i_mem_out;
                  default: begin
                     // read-only or unmapped: write ignored
                  end
               endcase
            end
            default: begin
               // nothing committed
            end
         endcase
      end
   end

   // Zero-extend the raw interrupt lines to a read word
   always_comb begin
      w_irq_ext = 32'd0;
      w_irq_ext[IRQ_CH-1:0] = i_irq;
   end

   // Read mux: no write bypass, a WRCR flush discards the reader anyway
   always_comb begin
      o_rd_data = 32'd0;
      case (i_rd_addr)
         CREG_ADDR_STATUS:     o_rd_data = creg_status_word(r_int_en, r_exe_mode);
         CREG_ADDR_PRE_STATUS: o_rd_data = creg_status_word(r_pre_int_en, r_pre_exe_mode);
         CREG_ADDR_EPC:        o_rd_data = {r_epc, 2'b00};
         CREG_ADDR_EXP_VECTOR: o_rd_data = {r_exp_vector, 2'b00};
         CREG_ADDR_CAUSE:      o_rd_data = {r_dly_flag, 28'd0, r_exp_code};
         CREG_ADDR_INT_MASK:   o_rd_data = r_int_mask;
         CREG_ADDR_IRQ:        o_rd_data = w_irq_ext;
         CREG_ADDR_ROM_SIZE:   o_rd_data = ROM_SIZE;
         CREG_ADDR_SPM_SIZE:   o_rd_data = SPM_SIZE;
         CREG_ADDR_CPU_INFO:   o_rd_data = {RELEASE_YEAR, RELEASE_MONTH,
                                            RELEASE_VERSION, RELEASE_REVISION};
         default:              o_rd_data = 32'd0;
      endcase
   end

   assign o_exe_mode   = r_exe_mode;
   assign o_int_en     = r_int_en;
   assign o_epc        = r_epc;
   assign o_exp_vector = r_exp_vector;
   assign o_int_mask   = r_int_mask[IRQ_CH-1:0];

endmodule

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline control for the IF/ID/EX/MEM CPU: per-stage stall and flush,
// MEM-stage commit of exceptions / WRCR / EXRT, redirect PC, interrupt
// detection and the control-register file (creg_file).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   irq                        external interrupt lines (level, high)
//   creg_rd_addr/creg_rd_data  RDCR read port (combinational)
//   exe_mode, int_detect       current mode, unmasked enabled interrupt
//   if_busy, mem_busy          bus interface busy -> global stall
//   ld_hazard                  load-use hazard -> ID flush (EX bubble)
//   *_stall, *_flush           pipeline register hold / invalidate
//   new_pc                     redirect target, valid while if_flush = 1
//   mem_*                      the instruction sitting in MEM
// ----------------------------------------------------------------------------
module pipe_ctrl
   import cpu_pkg::*;
#(
   parameter int          IRQ_CH         = 8,
   parameter logic [29:0] EXP_VECTOR_RST = 30'h0,
   parameter logic [31:0] ROM_SIZE       = 32'h2000,
   parameter logic [31:0] SPM_SIZE       = 32'h4000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IRQ_CH-1:0] irq,
   input  logic [4:0]        creg_rd_addr,
   output logic [31:0]       creg_rd_data,
   output logic              exe_mode,
   output logic              int_detect,
   input  logic              if_busy,
   input  logic              ld_hazard,
   input  logic              mem_busy,
   output logic              if_stall,
   output logic              id_stall,
   output logic              ex_stall,
   output logic              mem_stall,
   output logic              if_flush,
   output logic              id_flush,
   output logic              ex_flush,
   output logic              mem_flush,
   output logic [29:0]       new_pc,
   input  logic [29:0]       mem_pc,
   input  logic              mem_en,
   input  logic              mem_br_flag,
   input  logic [1:0]        mem_ctrl_op,
   input  logic [4:0]        mem_dst_addr,
   input  logic [2:0]        mem_exp_code,
   input  logic [31:0]       mem_out
);

   logic              w_stall;
   logic              w_commit_ok;
   commit_e           w_commit;
   logic              w_flush;
   logic [29:0]       w_new_pc;
   logic              w_int_en;
   logic [29:0]       w_epc;
   logic [29:0]       w_exp_vector;
   logic [IRQ_CH-1:0] w_int_mask;

   assign w_stall = if_busy | mem_busy;

   // Gating by rst_n keeps flush low and blocks commits while in reset
   assign w_commit_ok = rst_n & mem_en & ~w_stall;

   // Commit priority: exception, then EXRT, then WRCR
   always_comb begin
      w_commit = COMMIT_NONE;
      if (!w_commit_ok) begin
         w_commit = COMMIT_NONE;
      end else if (mem_exp_code != ISA_EXP_NO_EXP) begin
         w_commit = COMMIT_EXP;
      end else if (mem_ctrl_op == CTRL_OP_EXRT) begin
         w_commit = COMMIT_EXRT;
      end else if (mem_ctrl_op == CTRL_OP_WRCR) begin
         w_commit = COMMIT_WRCR;
      end else begin
         w_commit = COMMIT_NONE;
      end
   end

   // Flush and redirect target for the committing instruction
   always_comb begin
      w_flush  = 1'b0;
      w_new_pc = 30'd0;
      case (w_commit)
         COMMIT_EXP: begin
            w_flush  = 1'b1;
            w_new_pc = w_exp_vector;
         end
         COMMIT_EXRT: begin
            w_flush  = 1'b1;
            w_new_pc = w_epc;
         end
         COMMIT_WRCR: begin
            // restart after the WRCR so following instructions see the new value
            w_flush  = 1'b1;
            w_new_pc = mem_pc + 30'd1;
         end
         default: begin
            w_flush  = 1'b0;
            w_new_pc = 30'd0;
         end
      endcase
   end

   assign if_stall  = w_stall;
   assign id_stall  = w_stall;
   assign ex_stall  = w_stall;
   assign mem_stall = w_stall;

   assign if_flush  = w_flush;
   assign id_flush  = w_flush | ld_hazard;
   assign ex_flush  = w_flush;
   assign mem_flush = w_flush;

   assign new_pc     = w_new_pc;
   assign int_detect = w_int_en & (|(irq & ~w_int_mask));

   creg_file #(
      .IRQ_CH         (IRQ_CH),
      .EXP_VECTOR_RST (EXP_VECTOR_RST),
      .ROM_SIZE       (ROM_SIZE),
      .SPM_SIZE       (SPM_SIZE)
   ) u_creg_file (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_commit       (w_commit),
      .i_mem_pc       (mem_pc),
      .i_mem_br_flag  (mem_br_flag),
      .i_mem_exp_code (mem_exp_code),
      .i_mem_dst_addr (mem_dst_addr),
      .i_mem_out      (mem_out),
      .i_irq          (irq),
      .i_rd_addr      (creg_rd_addr),
      .o_rd_data      (creg_rd_data),
      .o_exe_mode     (exe_mode),
      .o_int_en       (w_int_en),
      .o_epc          (w_epc),
      .o_exp_vector   (w_exp_vector),
      .o_int_mask     (w_int_mask)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed, table-driven bench for pipe_ctrl. Each table row is one clock
// cycle: inputs are driven just after posedge, outputs are checked at the
// following negedge, and the posedge after that commits. A hand-written
// sequence covers reset asserted on the same edge as an exception commit.
// ----------------------------------------------------------------------------
module tb_pipe_ctrl;

   localparam logic [1:0] WR = 2'd1;
   localparam logic [1:0] EX = 2'd2;

   logic        clk;
   logic        rst_n;
   logic [7:0]  irq;
   logic [4:0]  creg_rd_addr;
   logic [31:0] creg_rd_data;
   logic        exe_mode;
   logic        int_detect;
   logic        if_busy;
   logic        ld_hazard;
   logic        mem_busy;
   logic        if_stall, id_stall, ex_stall, mem_stall;
   logic        if_flush, id_flush, ex_flush, mem_flush;
   logic [29:0] new_pc;
   logic [29:0] mem_pc;
   logic        mem_en;
   logic        mem_br_flag;
   logic [1:0]  mem_ctrl_op;
   logic [4:0]  mem_dst_addr;
   logic [2:0]  mem_exp_code;
   logic [31:0] mem_out;

   int n_tests;
   int n_fail;

   pipe_ctrl #(
      .IRQ_CH(8), .EXP_VECTOR_RST(30'h0), .ROM_SIZE(32'h2000), .SPM_SIZE(32'h4000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .irq(irq),
      .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data),
      .exe_mode(exe_mode), .int_detect(int_detect),
      .if_busy(if_busy), .ld_hazard(ld_hazard), .mem_busy(mem_busy),
      .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
      .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
      .new_pc(new_pc), .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag),
      .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr),
      .mem_exp_code(mem_exp_code), .mem_out(mem_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en, ifb, memb, ldh;
      logic [1:0]  op;
      logic [4:0]  dst;
      logic [2:0]  exc;
      logic        br;
      logic [29:0] pc;
      logic [31:0] wd;
      logic [7:0]  irqv;
      logic [4:0]  ra;
      logic        e_stall, e_flush, e_idf;
      logic [29:0] e_npc;
      logic [31:0] e_rd;
      logic        e_mode, e_intd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic en, input logic ifb, input logic memb, input logic ldh,
      input logic [1:0] op, input logic [4:0] dst, input logic [2:0] exc,
      input logic br, input logic [29:0] pc, input logic [31:0] wd,
      input logic [7:0] irqv, input logic [4:0] ra,
      input logic st, input logic fl, input logic idf, input logic [29:0] npc,
      input logic [31:0] rd, input logic md, input logic intd);
      vec_t v;
      v.en = en; v.ifb = ifb; v.memb = memb; v.ldh = ldh; v.op = op; v.dst = dst;
      v.exc = exc; v.br = br; v.pc = pc; v.wd = wd; v.irqv = irqv; v.ra = ra;
      v.e_stall = st; v.e_flush = fl; v.e_idf = idf; v.e_npc = npc;
      v.e_rd = rd; v.e_mode = md; v.e_intd = intd;
      return v;
   endfunction

   // idle cycle with only a read address and expected read/mode
   function automatic vec_t rd(input logic [4:0] ra, input logic [31:0] exp_rd,
                               input logic md);
      return mk(1'b0,1'b0,1'b0,1'b0,2'd0,5'd0,3'd0,1'b0,30'd0,32'd0,8'd0,ra,
                1'b0,1'b0,1'b0,30'd0,exp_rd,md,1'b0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
      end
   endtask

   task automatic drive_idle();
      mem_en = 1'b0; if_busy = 1'b0; mem_busy = 1'b0; ld_hazard = 1'b0;
      mem_ctrl_op = 2'd0; mem_dst_addr = 5'd0; mem_exp_code = 3'd0;
      mem_br_flag = 1'b0; mem_pc = 30'd0; mem_out = 32'd0; irq = 8'd0;
      creg_rd_addr = 5'd0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      drive_idle();

      // --- vector table ---
      vecs.push_back(rd(5'd0, 32'h0, 1'b0));                       // reset STATUS
      vecs.push_back(rd(5'd4, 32'h0, 1'b0));                       // EXP_VECTOR_RST<<2
      vecs.push_back(rd(5'd6, 32'hFFFF_FFFF, 1'b0));               // INT_MASK all masked
      vecs.push_back(mk(1,0,0,0,WR,5'd4,3'd0,0,30'h10,32'h100,8'd0,5'd4, 0,1,1,30'h11,32'h0,0,0));
      vecs.push_back(rd(5'd4, 32'h100, 1'b0));
      vecs.push_back(mk(1,0,0,0,WR,5'd0,3'd0,0,30'h12,32'h1,8'd0,5'd0, 0,1,1,30'h13,32'h0,0,0));
      vecs.push_back(rd(5'd0, 32'h1, 1'b1));                       // user mode
      vecs.push_back(mk(1,0,0,0,2'd0,5'd0,3'd2,1,30'h20,32'h0,8'd0,5'd0, 0,1,1,30'h40,32'h1,1,0));
      vecs.push_back(rd(5'd2, 32'h7C, 1'b0));                      // EPC = 0x1F
      vecs.push_back(rd(5'd5, 32'h8000_0002, 1'b0));               // CAUSE
      vecs.push_back(rd(5'd1, 32'h1, 1'b0));                       // PRE_STATUS
      vecs.push_back(mk(1,0,0,0,EX,5'd0,3'd0,0,30'h21,32'h0,8'd0,5'd0, 0,1,1,30'h1F,32'h0,0,0));
      vecs.push_back(rd(5'd0, 32'h1, 1'b1));                       // back to user
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(1,0,1,0,2'd0,5'd0,3'd3,0,30'h30,32'h0,8'd0,5'd5, 1,0,0,30'h0,32'h8000_0002,1,0));
      vecs.push_back(mk(1,0,0,0,2'd0,5'd0,3'd3,0,30'h30,32'h0,8'd0,5'd5, 0,1,1,30'h40,32'h8000_0002,1,0));
      vecs.push_back(rd(5'd2, 32'hC0, 1'b0));
      vecs.push_back(rd(5'd5, 32'h3, 1'b0));
      vecs.push_back(mk(1,1,0,0,WR,5'd6,3'd0,0,30'h40,32'hFE,8'd0,5'd6, 1,0,0,30'h0,32'hFFFF_FFFF,0,0));
      vecs.push_back(rd(5'd6, 32'hFFFF_FFFF, 1'b0));               // stalled WRCR dropped
      vecs.push_back(mk(1,0,0,0,WR,5'd6,3'd0,0,30'h40,32'hFE,8'd0,5'd6, 0,1,1,30'h41,32'hFFFF_FFFF,0,0));
      vecs.push_back(mk(1,0,0,0,WR,5'd0,3'd0,0,30'h41,32'h2,8'd0,5'd6, 0,1,1,30'h42,32'hFE,0,0));
      vecs.push_back(mk(0,0,0,0,2'd0,5'd0,3'd0,0,30'h0,32'h0,8'h02,5'd0, 0,0,0,30'h0,32'h2,0,0));
      vecs.push_back(mk(0,0,0,0,2'd0,5'd0,3'd0,0,30'h0,32'h0,8'h01,5'd7, 0,0,0,30'h0,32'h1,0,1));
      vecs.push_back(mk(0,0,0,1,2'd0,5'd0,3'd0,0,30'h0,32'h0,8'h01,5'd0, 0,0,1,30'h0,32'h2,0,1));
      vecs.push_back(mk(1,0,0,0,WR,5'd3,3'd0,0,30'h3FFF_FFFF,32'hDEAD,8'd0,5'd3, 0,1,1,30'h0,32'h0,0,0));
      vecs.push_back(rd(5'd3, 32'h0, 1'b0));                       // unmapped ignored
      vecs.push_back(rd(5'd8, 32'h2000, 1'b0));
      vecs.push_back(rd(5'd9, 32'h4000, 1'b0));
      vecs.push_back(rd(5'd10, 32'h2406_0100, 1'b0));
      vecs.push_back(mk(0,0,0,0,2'd0,5'd0,3'd1,0,30'h60,32'h0,8'd0,5'd5, 0,0,0,30'h0,32'h3,0,0));
      vecs.push_back(rd(5'd5, 32'h3, 1'b0));                       // invalid MEM no commit
      vecs.push_back(rd(5'd1, 32'h1, 1'b0));

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (vecs[k]) begin
         mem_en = vecs[k].en; if_busy = vecs[k].ifb; mem_busy = vecs[k].memb;
         ld_hazard = vecs[k].ldh; mem_ctrl_op = vecs[k].op; mem_dst_addr = vecs[k].dst;
         mem_exp_code = vecs[k].exc; mem_br_flag = vecs[k].br; mem_pc = vecs[k].pc;
         mem_out = vecs[k].wd; irq = vecs[k].irqv; creg_rd_addr = vecs[k].ra;
         @(negedge clk);
         chk($sformatf("v%0d stall", k), {28'd0, if_stall, id_stall, ex_stall, mem_stall},
             {28'd0, {4{vecs[k].e_stall}}});
         chk($sformatf("v%0d flush", k), {29'd0, if_flush, ex_flush, mem_flush},
             {29'd0, {3{vecs[k].e_flush}}});
         chk($sformatf("v%0d id_flush", k), {31'd0, id_flush}, {31'd0, vecs[k].e_idf});
         if (vecs[k].e_flush)
            chk($sformatf("v%0d new_pc", k), {2'd0, new_pc}, {2'd0, vecs[k].e_npc});
         chk($sformatf("v%0d rd_data", k), creg_rd_data, vecs[k].e_rd);
         chk($sformatf("v%0d exe_mode", k), {31'd0, exe_mode}, {31'd0, vecs[k].e_mode});
         chk($sformatf("v%0d int_detect", k), {31'd0, int_detect}, {31'd0, vecs[k].e_intd});
         @(posedge clk);
         #1;
      end

      // --- reset on the same edge as an exception commit ---
      drive_idle();
      rst_n = 1'b0; mem_en = 1'b1; mem_exp_code = 3'd5; mem_pc = 30'h50; mem_br_flag = 1'b1;
      @(negedge clk);
      chk("rst_exp if_flush", {31'd0, if_flush}, 32'd0);
      @(posedge clk);
      #1;
      drive_idle();
      rst_n = 1'b1;
      creg_rd_addr = 5'd2;
      @(negedge clk);
      chk("rst_exp EPC", creg_rd_data, 32'h0);
      creg_rd_addr = 5'd0;
      #1 chk("rst_exp STATUS", creg_rd_data, 32'h0);
      creg_rd_addr = 5'd5;
      #1 chk("rst_exp CAUSE", creg_rd_data, 32'h0);
      creg_rd_addr = 5'd1;
      #1 chk("rst_exp PRE_STATUS", creg_rd_data, 32'h0);
      creg_rd_addr = 5'd6;
      #1 chk("rst_exp INT_MASK", creg_rd_data, 32'hFFFF_FFFF);
      creg_rd_addr = 5'd4;
      #1 chk("rst_exp EXP_VECTOR", creg_rd_data, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
